// File: rtl/led_bar_fader.sv
// led_bar_fader: per-LED PWM drive with afterglow; a lit LED jumps to full, then fades linearly once released.
// Define LED_BAR_FADER_GAMMA_EN to square the level at the duty latch for a perceptually linear fade.
module led_bar_fader #(
  parameter int N_LEDS      = 10,
  parameter int PWM_BITS    = 8,
  parameter int DECAY_TICKS = 50000,
  parameter int DECAY_STEP  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] pat_in,
  input  logic              pat_valid,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_tick
);

  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
  localparam logic [DW-1:0]       DEC_LAST = DW'(DECAY_TICKS - 1);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(DECAY_STEP);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       decay_cnt;
  logic                decay_hit;
  logic                frame_end;
  logic [N_LEDS-1:0]   led_nxt;

  assign decay_hit = (decay_cnt == DEC_LAST);
  assign frame_end = (pwm_cnt == PWM_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt    <= '0;
      decay_cnt  <= '0;
      frame_tick <= 1'b0;
      led_out    <= '0;
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      decay_cnt  <= decay_hit ? '0 : decay_cnt + DW'(1);
      frame_tick <= frame_end;
      led_out    <= led_nxt;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [PWM_BITS:0]   dec_diff;

    // One bit wider so an underflow shows up as the top bit and clamps to zero.
    assign dec_diff = {1'b0, level} - STEP_W;

`ifdef LED_BAR_FADER_GAMMA_EN
    assign duty_nxt = PWM_BITS'(({{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level}) >> PWM_BITS);
`else
    assign duty_nxt = level;
`endif

    assign led_nxt[i] = (duty > pwm_cnt);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        level <= '0;
        duty  <= '0;
      end else begin
        if (pat_valid && pat_in[i]) begin
          level <= PWM_MAX;
        end else if (decay_hit) begin
          level <= dec_diff[PWM_BITS] ? '0 : dec_diff[PWM_BITS-1:0];
        end
        // Duty only moves at the frame boundary so a PWM period never glitches.
        if (frame_end) begin
          duty <= duty_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_bar_fader.sv
// Randomized bench for led_bar_fader against a frame-level behavioural model.
module tb_led_bar_fader;

  localparam int N    = 10;
  localparam int PB   = 4;
  localparam int DT   = 4;
  localparam int DS   = 3;
  localparam int PMAX = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pat_valid = 1'b0;
  logic [N-1:0] pat_in = '0;
  logic [N-1:0] led_out;
  logic         frame_tick;

  logic         g_rst = 1'b1;
  logic         g_pv = 1'b0;
  logic [N-1:0] g_pat = '0;
  logic [N-1:0] s_led, g1_led, g2_led;
  logic         s_ft, g1_ft, g2_ft;

  int checks = 0;
  int failures = 0;

  int           m_level[N];
  int           m_duty[N];
  int           m_pwm;
  int           m_dec;
  logic [N-1:0] m_led;
  logic         m_ft;

  always #5 clk = ~clk;

  led_bar_fader #(.N_LEDS(N), .PWM_BITS(PB), .DECAY_TICKS(DT), .DECAY_STEP(DS)) u_dut (
    .clk(clk), .rst(rst), .pat_in(pat_in), .pat_valid(pat_valid),
    .led_out(led_out), .frame_tick(frame_tick));

  led_bar_fader #(.N_LEDS(N), .PWM_BITS(PB), .DECAY_TICKS(DT), .DECAY_STEP(13)) u_s (
    .clk(clk), .rst(g_rst), .pat_in(g_pat), .pat_valid(g_pv),
    .led_out(s_led), .frame_tick(s_ft));

  led_bar_fader #(.N_LEDS(N), .PWM_BITS(8), .DECAY_TICKS(256), .DECAY_STEP(127)) u_g1 (
    .clk(clk), .rst(g_rst), .pat_in(g_pat), .pat_valid(g_pv),
    .led_out(g1_led), .frame_tick(g1_ft));

  led_bar_fader #(.N_LEDS(N), .PWM_BITS(8), .DECAY_TICKS(256), .DECAY_STEP(240)) u_g2 (
    .clk(clk), .rst(g_rst), .pat_in(g_pat), .pat_valid(g_pv),
    .led_out(g2_led), .frame_tick(g2_ft));

  function automatic int fmap(int x, int bits);
`ifdef LED_BAR_FADER_GAMMA_EN
    return (x * x) >> bits;
`else
    return (x > (1 << bits) - 1) ? (1 << bits) - 1 : x;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_level[i] = 0;
      m_duty[i]  = 0;
    end
    m_pwm = 0;
    m_dec = 0;
    m_led = '0;
    m_ft  = 1'b0;
  endtask

  // Next state from the current model state and the inputs about to be sampled.
  task automatic model_step();
    int nl[N];
    int nd[N];
    for (int i = 0; i < N; i++) begin
      m_led[i] = (m_duty[i] > m_pwm);
      nd[i] = (m_pwm == PMAX) ? fmap(m_level[i], PB) : m_duty[i];
      if (pat_valid && pat_in[i]) nl[i] = PMAX;
      else if (m_dec == DT - 1) nl[i] = (m_level[i] - DS < 0) ? 0 : m_level[i] - DS;
      else nl[i] = m_level[i];
    end
    m_ft = (m_pwm == PMAX);
    for (int i = 0; i < N; i++) begin
      m_level[i] = nl[i];
      m_duty[i]  = nd[i];
    end
    m_pwm = (m_pwm + 1) % (PMAX + 1);
    m_dec = (m_dec + 1) % DT;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks += 2;
    if (led_out !== '0) begin failures++; $display("FAIL reset_led got=%h exp=0", led_out); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_ft got=%b exp=0", frame_tick); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_on();
    int ones = 0;
    int fts = 0;
    pat_in = 10'h001;
    pat_valid = 1'b1;
    for (int t = 1; t <= 48; t++) begin
      tick();
      checks += 3;
      if (led_out !== m_led) begin failures++; $display("FAIL full_led t=%0d got=%h exp=%h", t, led_out, m_led); end
      if (frame_tick !== m_ft) begin failures++; $display("FAIL full_ft t=%0d got=%b exp=%b", t, frame_tick, m_ft); end
      if (led_out[N-1:1] !== '0) begin failures++; $display("FAIL full_upper t=%0d got=%h exp=0", t, led_out[N-1:1]); end
      if (t > 32) ones += int'(led_out[0]);
      fts += int'(frame_tick);
    end
    checks += 2;
    if (ones != 15) begin failures++; $display("FAIL full_duty got=%0d exp=15", ones); end
    if (fts != 3) begin failures++; $display("FAIL full_ftcount got=%0d exp=3", fts); end
  endtask

  task automatic test_fade();
    int seg[$];
    int cnt = 0;
    bit started = 0;
    pat_in = 10'h200;
    pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
    for (int t = 0; t < 128 && seg.size() < 6; t++) begin
      pat_in = N'($urandom);
      tick();
      checks += 2;
      if (led_out !== m_led) begin failures++; $display("FAIL fade_led t=%0d got=%h exp=%h", t, led_out, m_led); end
      if (frame_tick !== m_ft) begin failures++; $display("FAIL fade_ft t=%0d got=%b exp=%b", t, frame_tick, m_ft); end
      if (frame_tick) begin
        if (started) seg.push_back(cnt);
        started = 1;
        cnt = 0;
      end
      if (started) cnt += int'(led_out[9]);
    end
    checks++;
    if (seg.size() != 6) begin
      failures++;
      $display("FAIL fade_frames got=%0d exp=6", seg.size());
    end else begin
`ifndef LED_BAR_FADER_GAMMA_EN
      checks++;
      if (seg[0] <= 0) begin failures++; $display("FAIL fade_first got=%0d exp>0", seg[0]); end
`endif
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (seg[k] > seg[k-1]) begin failures++; $display("FAIL fade_mono k=%0d got=%0d exp<=%0d", k, seg[k], seg[k-1]); end
      end
      checks++;
      if (seg[5] != 0) begin failures++; $display("FAIL fade_dark got=%0d exp=0", seg[5]); end
    end
  endtask

  task automatic test_set_vs_decay();
    bit found = 0;
    pat_in = 10'h028;
    pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
    pat_in = '0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_dec == DT - 1 && m_level[3] == 6) begin
        pat_valid = 1'b1;
        pat_in = 10'h008;
        tick();
        pat_valid = 1'b0;
        found = 1;
        checks += 2;
        if (u_dut.g_ch[3].level !== 4'd15) begin failures++; $display("FAIL set_beats_decay got=%0d exp=15", u_dut.g_ch[3].level); end
        if (u_dut.g_ch[5].level !== 4'd3) begin failures++; $display("FAIL other_decays got=%0d exp=3", u_dut.g_ch[5].level); end
      end else begin
        tick();
      end
      checks++;
      if (led_out !== m_led) begin failures++; $display("FAIL svd_led k=%0d got=%h exp=%h", k, led_out, m_led); end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL svd_timeout got=0 exp=1"); end
  endtask

  task automatic test_ignore();
    bit idle = 0;
    pat_valid = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      tick();
      checks++;
      if (led_out !== m_led) begin failures++; $display("FAIL ign_settle_led k=%0d got=%h exp=%h", k, led_out, m_led); end
      idle = 1;
      for (int i = 0; i < N; i++) if (m_level[i] != 0 || m_duty[i] != 0) idle = 0;
    end
    pat_in = 10'h3FF;
    for (int t = 0; t < 32; t++) begin
      tick();
      checks++;
      if (led_out !== '0) begin failures++; $display("FAIL ignore_dark t=%0d got=%h exp=0", t, led_out); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      pat_valid = ($urandom_range(0, 7) == 0);
      pat_in = N'($urandom);
      tick();
      checks += 2;
      if (led_out !== m_led) begin failures++; $display("FAIL rand_led t=%0d got=%h exp=%h", t, led_out, m_led); end
      if (frame_tick !== m_ft) begin failures++; $display("FAIL rand_ft t=%0d got=%b exp=%b", t, frame_tick, m_ft); end
    end
  endtask

  task automatic test_reset_midrun();
    pat_in = 10'h3FF;
    pat_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++;
      if (led_out !== m_led) begin failures++; $display("FAIL pre_rst_led t=%0d got=%h exp=%h", t, led_out, m_led); end
    end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (led_out !== '0) begin failures++; $display("FAIL midrst_led got=%h exp=0", led_out); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL midrst_ft got=%b exp=0", frame_tick); end
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    for (int t = 1; t <= 32; t++) begin
      tick();
      checks++;
      if (led_out !== m_led) begin failures++; $display("FAIL post_rst_led t=%0d got=%h exp=%h", t, led_out, m_led); end
      if (t <= 16) begin
        checks++;
        if (led_out !== '0) begin failures++; $display("FAIL post_rst_dark t=%0d got=%h exp=0", t, led_out); end
      end
    end
  endtask

  task automatic test_saturation();
    int seq[$];
    int last = -1;
    int v;
    g_pat = 10'h001;
    @(negedge clk);
    g_rst = 1'b0;
    g_pv = 1'b1;
    @(negedge clk);
    g_pv = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      v = int'(u_s.g_ch[0].level);
      if (v != last) seq.push_back(v);
      last = v;
    end
    checks++;
    if (seq.size() != 3) begin
      failures++;
      $display("FAIL sat_len got=%0d exp=3", seq.size());
    end else begin
      checks += 3;
      if (seq[0] != 15) begin failures++; $display("FAIL sat_full got=%0d exp=15", seq[0]); end
      if (seq[1] != 2) begin failures++; $display("FAIL sat_mid got=%0d exp=2", seq[1]); end
      if (seq[2] != 0) begin failures++; $display("FAIL sat_zero got=%0d exp=0", seq[2]); end
    end
  endtask

  task automatic test_gamma();
    int e1[3] = '{255, 128, 1};
    int e2[3] = '{255, 15, 0};
    bit seen;
    for (int f = 0; f < 3; f++) begin
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
        @(negedge clk);
        if (g1_ft) seen = 1;
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL gamma_tick_timeout f=%0d got=0 exp=1", f);
      end else begin
        checks += 2;
        if (int'(u_g1.g_ch[0].duty) != fmap(e1[f], 8)) begin
          failures++; $display("FAIL gamma_g1 f=%0d got=%0d exp=%0d", f, u_g1.g_ch[0].duty, fmap(e1[f], 8));
        end
        if (int'(u_g2.g_ch[0].duty) != fmap(e2[f], 8)) begin
          failures++; $display("FAIL gamma_g2 f=%0d got=%0d exp=%0d", f, u_g2.g_ch[0].duty, fmap(e2[f], 8));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_on();
    test_fade();
    test_set_vs_decay();
    test_ignore();
    test_random();
    test_reset_midrun();
    test_saturation();
    test_gamma();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
